trace_config_sequencer: RTL

Sequences reconfiguration of the instrumentation chain, including the data packers, filters and reduce units. It owns the shared tracing, configId and configData broadcast bus. On request, it stops tracing, lets the pipeline drain, then streams each block's firmware bytes under that block's config ID, with one idle-ID gap between blocks so each block's byte counter restarts. It then resumes tracing. Firmware bytes and per-block lengths are written by the host beforehand through a simple write port.

---
 rtl/trace_config_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/trace_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trace_config_sequencer
// Brief    : Stops tracing, drains the pipeline, streams each block's firmware
//            on the shared configId/configData bus, then resumes tracing.
// Revision : 1.0
// ============================================================================
module trace_config_sequencer #(
    parameter int         NUM_BLOCKS     = 4,
    parameter int         MAX_BYTES      = 16,
    parameter int         CONFIG_ID_BASE = 0,
    parameter logic [7:0] IDLE_CONFIG_ID = 8'hFF,
    parameter int         DRAIN_CYCLES   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             trace_enable,
    input  logic                             start,
    input  logic                             wr_en,
    input  logic [$clog2(NUM_BLOCKS)-1:0]    wr_block,
    input  logic [$clog2(MAX_BYTES)-1:0]     wr_addr,
    input  logic [7:0]                       wr_data,
    input  logic                             len_wr_en,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   len_data,
    output logic                             tracing,
    output logic [7:0]                       configId,
    output logic [7:0]                       configData,
    output logic                             busy,
    output logic                             done,
    output logic                             wr_err
);

    localparam int c_BLK_W = $clog2(NUM_BLOCKS);
    localparam int c_BYT_W = $clog2(MAX_BYTES);
    localparam int c_LEN_W = $clog2(MAX_BYTES + 1);
    localparam int c_DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [c_LEN_W-1:0] c_MAX_LEN   = c_LEN_W'(MAX_BYTES);
    localparam logic [c_BLK_W-1:0] c_LAST_BLK  = c_BLK_W'(NUM_BLOCKS - 1);
    localparam logic [c_DRN_W-1:0] c_DRAIN_END = c_DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [7:0]         c_ID_BASE   = 8'(CONFIG_ID_BASE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_SEND   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_BLK_W-1:0]   r_block;
    logic [c_BYT_W-1:0]   r_byte;
    logic [c_DRN_W-1:0]   r_drain;
    logic [7:0]           r_fw  [NUM_BLOCKS][MAX_BYTES];
    logic [c_LEN_W-1:0]   r_len [NUM_BLOCKS];

    logic                 r_tracing;
    logic [7:0]           r_id;
    logic [7:0]           r_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_wr_err;

    state_t               w_state_nx;
    logic [c_BLK_W-1:0]   w_block_nx;
    logic [c_BLK_W-1:0]   w_block_inc;
    logic [c_BYT_W-1:0]   w_byte_nx;
    logic [c_DRN_W-1:0]   w_drain_nx;
    logic [7:0]           w_id_nx;
    logic [7:0]           w_data_nx;
    logic [c_LEN_W-1:0]   w_len_clamped;
    logic                 w_idle;

    assign w_idle        = (r_state == S_IDLE);
    assign w_block_inc   = r_block + c_BLK_W'(1);
    assign w_len_clamped = (len_data > c_MAX_LEN) ? c_MAX_LEN : len_data;

    // Firmware storage is a plain RAM; it keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en && w_idle) begin
            r_fw[wr_block][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_len[i] <= '0;
            end
        end else if (len_wr_en && w_idle) begin
            r_len[wr_block] <= w_len_clamped;
        end
    end

    // Outputs are registered from the next-state view so the bus value seen in
    // a cycle always matches the state occupying that cycle.
    always_comb begin
        w_state_nx = r_state;
        w_block_nx = r_block;
        w_byte_nx  = r_byte;
        w_drain_nx = r_drain;
        w_id_nx    = IDLE_CONFIG_ID;
        w_data_nx  = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_DRAIN;
                    w_drain_nx = '0;
                end
            end
            S_DRAIN: begin
                if (r_drain == c_DRAIN_END) begin
                    w_block_nx = '0;
                    w_byte_nx  = '0;
                    w_state_nx = (r_len[0] != '0) ? S_SEND : S_GAP;
                end else begin
                    w_drain_nx = r_drain + c_DRN_W'(1);
                end
            end
            S_SEND: begin
                if (c_LEN_W'(r_byte) == (r_len[r_block] - c_LEN_W'(1))) begin
                    w_state_nx = S_GAP;
                end else begin
                    w_byte_nx = r_byte + c_BYT_W'(1);
                end
            end
            S_GAP: begin
                if (r_block == c_LAST_BLK) begin
                    w_state_nx = S_FINISH;
                end else begin
                    // A zero-length block is represented by its own gap cycle.
                    w_block_nx = w_block_inc;
                    w_byte_nx  = '0;
                    w_state_nx = (r_len[w_block_inc] != '0) ? S_SEND : S_GAP;
                end
            end
            S_FINISH: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_state_nx == S_SEND) begin
            w_id_nx   = c_ID_BASE + 8'(w_block_nx);
            w_data_nx = r_fw[w_block_nx][w_byte_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_block   <= '0;
            r_byte    <= '0;
            r_drain   <= '0;
            r_tracing <= 1'b0;
            r_id      <= IDLE_CONFIG_ID;
            r_data    <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_block   <= w_block_nx;
            r_byte    <= w_byte_nx;
            r_drain   <= w_drain_nx;
            r_tracing <= (w_state_nx == S_IDLE) && trace_enable;
            r_id      <= w_id_nx;
            r_data    <= w_data_nx;
            r_busy    <= (w_state_nx != S_IDLE);
            r_done    <= (w_state_nx == S_FINISH);
            r_wr_err  <= !w_idle && (wr_en || len_wr_en);
        end
    end

    assign tracing    = r_tracing;
    assign configId   = r_id;
    assign configData = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign wr_err     = r_wr_err;

endmodule
`default_nettype wire
